// File: rtl/seg_display_pkg.sv
// Shared constants and helpers for the seven-segment scan controller.
package seg_display_pkg;

    // Widest display supported by the anode helper below.
    localparam int MAX_DIGITS = 32;

    // Decimal point line level when the point is dark (active-low).
    localparam logic DP_OFF = 1'b1;

    // Counter/index width for a modulo-n count: clog2(n), at least 1 bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // All-ones anode mask for n digits (every digit dark); callers truncate to their width.
    function automatic logic [MAX_DIGITS-1:0] anode_off(input int n);
        logic [MAX_DIGITS-1:0] mask;
        mask = '0;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (i < n) begin
                mask[i] = 1'b1;
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/refresh_tick_gen.sv
// Modulo-REFRESH_COUNT slot counter; slot_tick marks the last cycle of each slot.
module refresh_tick_gen
    import seg_display_pkg::*;
#(
    parameter int REFRESH_COUNT = 12500,
    parameter int CNT_W         = idx_width(REFRESH_COUNT)
) (
    input  logic             clk,
    input  logic             reset,
    output logic             slot_tick,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(REFRESH_COUNT - 1);

    assign slot_tick = (count == LAST_COUNT);

    // Free-running slot counter, wrapping to 0 after the tick cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (slot_tick) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/seg_display_scanner.sv
// Time-multiplexed scan controller for a common-anode multi-digit 7-segment display.
// Keeps a shadow copy of the display value and presents one nibble per slot to the decoder.
module seg_display_scanner
    import seg_display_pkg::*;
#(
    parameter int NUM_DIGITS    = 8,
    parameter int REFRESH_COUNT = 12500,
    parameter int GUARD_CYCLES  = 2
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               load,
    input  logic [4*NUM_DIGITS-1:0]            data_in,
    input  logic [NUM_DIGITS-1:0]              dp_in,
    input  logic [NUM_DIGITS-1:0]              digit_en,
    input  logic                               lzb,
    output logic [3:0]                         hex,
    output logic [NUM_DIGITS-1:0]              anode,
    output logic                               dp,
    output logic [idx_width(NUM_DIGITS)-1:0]   digit_idx
);

    localparam int IDX_W = idx_width(NUM_DIGITS);
    localparam int CNT_W = idx_width(REFRESH_COUNT);
    // NUM_DIGITS is limited to MAX_DIGITS by the width of the helper mask.
    localparam logic [NUM_DIGITS-1:0] ANODE_ALL = NUM_DIGITS'(anode_off(NUM_DIGITS));
    localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]        tick_count;
    logic                    slot_tick;
    logic [4*NUM_DIGITS-1:0] shadow_data;
    logic [NUM_DIGITS-1:0]   shadow_dp;
    logic [3:0]              cur_nibble;
    logic                    lead_zero;
    logic                    in_guard;
    logic                    dark;

    refresh_tick_gen #(
        .REFRESH_COUNT (REFRESH_COUNT),
        .CNT_W         (CNT_W)
    ) u_tick (
        .clk       (clk),
        .reset     (reset),
        .slot_tick (slot_tick),
        .count     (tick_count)
    );

    // Step to the next digit after the last cycle of each slot; explicit wrap keeps
    // non-power-of-two digit counts free of dead slots.
    always_ff @(posedge clk) begin
        if (reset) begin
            digit_idx <= '0;
        end else if (slot_tick) begin
            digit_idx <= (digit_idx == LAST_IDX) ? '0 : digit_idx + IDX_W'(1);
        end
    end

    // Shadow copy of the display value and decimal points, updated only on load.
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_data <= '0;
            shadow_dp   <= '0;
        end else if (load) begin
            shadow_data <= data_in;
            shadow_dp   <= dp_in;
        end
    end

    // Select the active nibble and decide whether the active digit stays dark.
    // Leading zeros: the active digit and every digit above it are zero; digit 0 is exempt.
    always_comb begin
        cur_nibble = shadow_data[{digit_idx, 2'b00} +: 4];
        lead_zero  = (digit_idx != '0) && ((shadow_data >> {digit_idx, 2'b00}) == '0);
        in_guard   = (tick_count < CNT_W'(GUARD_CYCLES));
        dark       = ~digit_en[digit_idx] | (lzb & lead_zero) | in_guard;
    end

    // Registered drive stage; a dark digit still presents its nibble to keep the decoder stable.
    always_ff @(posedge clk) begin
        if (reset) begin
            hex   <= 4'h0;
            anode <= ANODE_ALL;
            dp    <= DP_OFF;
        end else begin
            hex <= cur_nibble;
            if (dark) begin
                anode <= ANODE_ALL;
                dp    <= DP_OFF;
            end else begin
                anode <= ~(NUM_DIGITS'(1) << digit_idx);
                dp    <= ~shadow_dp[digit_idx];
            end
        end
    end

endmodule
